// File: rtl/ahbl_arb2.sv
// rtl/ahbl_arb2.sv - two-master to one-slave AHB-Lite arbiter with per-master hold buffers
module ahbl_arb2 #(
    parameter int W_ADDR = 32,
    parameter int W_DATA = 32,
    parameter bit RR     = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [W_ADDR-1:0] s0_haddr,
    input  logic              s0_hwrite,
    input  logic [2:0]        s0_hsize,
    input  logic [2:0]        s0_hburst,
    input  logic [3:0]        s0_hprot,
    input  logic              s0_hmastlock,
    input  logic [1:0]        s0_htrans,
    input  logic [W_DATA-1:0] s0_hwdata,
    output logic              s0_hready,
    output logic              s0_hresp,
    output logic [W_DATA-1:0] s0_hrdata,
    input  logic [W_ADDR-1:0] s1_haddr,
    input  logic              s1_hwrite,
    input  logic [2:0]        s1_hsize,
    input  logic [2:0]        s1_hburst,
    input  logic [3:0]        s1_hprot,
    input  logic              s1_hmastlock,
    input  logic [1:0]        s1_htrans,
    input  logic [W_DATA-1:0] s1_hwdata,
    output logic              s1_hready,
    output logic              s1_hresp,
    output logic [W_DATA-1:0] s1_hrdata,
    output logic [W_ADDR-1:0] m_haddr,
    output logic              m_hwrite,
    output logic [1:0]        m_htrans,
    output logic [2:0]        m_hsize,
    output logic [2:0]        m_hburst,
    output logic [3:0]        m_hprot,
    output logic              m_hmastlock,
    output logic [7:0]        m_hmaster,
    output logic [W_DATA-1:0] m_hwdata,
    input  logic              m_hready,
    input  logic              m_hresp,
    input  logic [W_DATA-1:0] m_hrdata
);
    localparam logic [1:0] HT_IDLE = 2'b00;
    localparam logic [1:0] HT_BUSY = 2'b01;
    localparam logic [1:0] HT_SEQ  = 2'b11;

    typedef struct packed {
        logic [W_ADDR-1:0] addr;
        logic              write;
        logic [2:0]        size;
        logic [2:0]        burst;
        logic [3:0]        prot;
        logic              lock;
        logic [1:0]        trans;
    } aph_t;

    aph_t       live [2];
    aph_t       hold [2];
    aph_t       src  [2];
    aph_t       m_aph;
    logic [1:0] hold_vld, live_req, own_dph, elig, act, s_hready;
    logic       dph_vld, dph_owner, last_grant, aph_frz, frz_idx, lock_vld, lock_idx;
    logic       retain, tie_pick, issue, grant, xfer;

    assign live[0] = {s0_haddr, s0_hwrite, s0_hsize, s0_hburst, s0_hprot, s0_hmastlock, s0_htrans};
    assign live[1] = {s1_haddr, s1_hwrite, s1_hsize, s1_hburst, s1_hprot, s1_hmastlock, s1_htrans};

    // Per-master source (hold wins over live), eligibility and ready back to the master
    always_comb begin
        for (int n = 0; n < 2; n++) begin
            src[n]      = hold_vld[n] ? hold[n] : live[n];
            live_req[n] = live[n].trans[1] & ~hold_vld[n];
            own_dph[n]  = dph_vld & (dph_owner == n[0]);
            elig[n]     = hold_vld[n] | (live_req[n] & (m_hready | own_dph[n]));
            act[n]      = hold_vld[n] | ((live[n].trans != HT_IDLE) & (m_hready | own_dph[n]));
            s_hready[n] = own_dph[n] ? m_hready : ~hold_vld[n];
        end
    end

    // Grant: frozen wait-state grant, then burst/lock retention, then held, then live
    always_comb begin
        tie_pick = RR ? ~last_grant : 1'b0;
        retain   = lock_vld & ((src[lock_idx].trans == HT_SEQ) |
                               (src[lock_idx].trans == HT_BUSY) | src[lock_idx].lock);
        issue    = 1'b0;
        grant    = 1'b0;
        if (aph_frz) begin
            issue = 1'b1;
            grant = frz_idx;
        end else if (retain) begin
            issue = act[lock_idx];
            grant = lock_idx;
        end else if (hold_vld != 2'b00) begin
            issue = 1'b1;
            grant = (hold_vld == 2'b11) ? tie_pick : hold_vld[1];
        end else if (elig != 2'b00) begin
            issue = 1'b1;
            grant = (elig == 2'b11) ? tie_pick : elig[1];
        end
        m_aph = issue ? src[grant] : '0;
        xfer  = issue & m_aph.trans[1];
    end

    assign m_haddr     = m_aph.addr;
    assign m_hwrite    = m_aph.write;
    assign m_hsize     = m_aph.size;
    assign m_hburst    = m_aph.burst;
    assign m_hprot     = m_aph.prot;
    assign m_hmastlock = m_aph.lock;
    assign m_htrans    = m_aph.trans;
    assign m_hmaster   = {7'b0, issue & grant};
    assign m_hwdata    = dph_owner ? s1_hwdata : s0_hwdata;
    assign s0_hready   = s_hready[0];
    assign s1_hready   = s_hready[1];
    assign s0_hresp    = own_dph[0] & m_hresp;
    assign s1_hresp    = own_dph[1] & m_hresp;
    assign s0_hrdata   = m_hrdata;
    assign s1_hrdata   = m_hrdata;

    // Hold capture/release, data-phase ownership, retention, round-robin and freeze state
    always_ff @(posedge clk) begin
        if (rst) begin
            hold[0]    <= '0;
            hold[1]    <= '0;
            hold_vld   <= 2'b00;
            dph_vld    <= 1'b0;
            dph_owner  <= 1'b0;
            last_grant <= 1'b1;
            aph_frz    <= 1'b0;
            frz_idx    <= 1'b0;
            lock_vld   <= 1'b0;
            lock_idx   <= 1'b0;
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (live_req[n] & ~(issue & (grant == n[0])) & s_hready[n]) begin
                    hold[n]     <= live[n];
                    hold_vld[n] <= 1'b1;
                end else if (hold_vld[n] & issue & (grant == n[0]) & m_hready) begin
                    hold_vld[n] <= 1'b0;
                end
            end
            if (m_hready) begin
                dph_vld  <= xfer;
                lock_vld <= issue & (m_aph.lock | (m_aph.burst != 3'b000));
                if (issue) lock_idx <= grant;
                if (xfer) begin
                    dph_owner  <= grant;
                    last_grant <= grant;
                end
            end
            // An error response releases the freeze so the owner may cancel to IDLE
            aph_frz <= ~m_hready & xfer & ~m_hresp;
            frz_idx <= grant;
        end
    end
endmodule

// File: tb/tb_ahbl_arb2.sv
// tb/tb_ahbl_arb2.sv - table-driven bench for ahbl_arb2 (fixed-priority and round-robin instances)
module tb_ahbl_arb2;
    localparam logic [1:0] I = 2'b00;
    localparam logic [1:0] N = 2'b10;
    localparam logic [1:0] S = 2'b11;
    localparam logic [31:0] WD0 = 32'hA0A0_0000;
    localparam logic [31:0] WD1 = 32'hB1B1_0001;
    localparam logic [31:0] RD  = 32'hC0DE_F00D;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] s0_haddr = '0, s1_haddr = '0;
    logic [1:0]  s0_htrans = I, s1_htrans = I;
    logic [2:0]  s0_hburst = '0, s1_hburst = '0;
    logic        m_hready = 1'b1, m_hresp = 1'b0;

    logic        o_s0_hready [2], o_s0_hresp [2], o_s1_hready [2], o_s1_hresp [2];
    logic [31:0] o_s0_hrdata [2], o_s1_hrdata [2], o_haddr [2], o_hwdata [2];
    logic        o_hwrite [2], o_hmastlock [2];
    logic [1:0]  o_htrans [2];
    logic [2:0]  o_hsize [2], o_hburst [2];
    logic [3:0]  o_hprot [2];
    logic [7:0]  o_hmaster [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        ahbl_arb2 #(.W_ADDR(32), .W_DATA(32), .RR(g == 1)) dut (
            .clk(clk), .rst(rst),
            .s0_haddr(s0_haddr), .s0_hwrite(1'b0), .s0_hsize(3'd2), .s0_hburst(s0_hburst),
            .s0_hprot(4'h3), .s0_hmastlock(1'b0), .s0_htrans(s0_htrans), .s0_hwdata(WD0),
            .s0_hready(o_s0_hready[g]), .s0_hresp(o_s0_hresp[g]), .s0_hrdata(o_s0_hrdata[g]),
            .s1_haddr(s1_haddr), .s1_hwrite(1'b0), .s1_hsize(3'd2), .s1_hburst(s1_hburst),
            .s1_hprot(4'h3), .s1_hmastlock(1'b0), .s1_htrans(s1_htrans), .s1_hwdata(WD1),
            .s1_hready(o_s1_hready[g]), .s1_hresp(o_s1_hresp[g]), .s1_hrdata(o_s1_hrdata[g]),
            .m_haddr(o_haddr[g]), .m_hwrite(o_hwrite[g]), .m_htrans(o_htrans[g]),
            .m_hsize(o_hsize[g]), .m_hburst(o_hburst[g]), .m_hprot(o_hprot[g]),
            .m_hmastlock(o_hmastlock[g]), .m_hmaster(o_hmaster[g]), .m_hwdata(o_hwdata[g]),
            .m_hready(m_hready), .m_hresp(m_hresp), .m_hrdata(RD)
        );
    end

    typedef struct {
        logic        rst;
        logic [1:0]  t0;
        logic [31:0] a0;
        logic [2:0]  b0;
        logic [1:0]  t1;
        logic [31:0] a1;
        logic        mr, me;
        logic [1:0]  et;
        logic [31:0] ea;
        logic        em, r0, r1, e0, e1;
    } vec_t;

    vec_t vq[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic add(input logic r, input logic [1:0] t0, input logic [31:0] a0, input logic [2:0] b0,
                       input logic [1:0] t1, input logic [31:0] a1, input logic mr, input logic me,
                       input logic [1:0] et, input logic [31:0] ea, input logic em,
                       input logic r0, input logic r1, input logic e0, input logic e1);
        vec_t v;
        v = '{r, t0, a0, b0, t1, a1, mr, me, et, ea, em, r0, r1, e0, e1};
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drv(input logic r, input logic [1:0] t0, input logic [31:0] a0,
                       input logic [1:0] t1, input logic [31:0] a1);
        @(negedge clk);
        rst = r; s0_htrans = t0; s0_haddr = a0; s0_hburst = 3'd0;
        s1_htrans = t1; s1_haddr = a1; m_hready = 1'b1; m_hresp = 1'b0;
        #2;
    endtask

    initial begin
        //  rst t0 a0       b0 t1 a1      mr me   et ea       em r0 r1 e0 e1
        add(1, I, 32'h0,    0, I, 32'h0,   1, 0,   I, 32'h0,    0, 1, 1, 0, 0); // reset state
        add(0, N, 32'h1000, 0, I, 32'h0,   1, 0,   N, 32'h1000, 0, 1, 1, 0, 0); // pass-through
        add(0, I, 32'h0,    0, I, 32'h0,   1, 0,   I, 32'h0,    0, 1, 1, 0, 0);
        add(0, N, 32'h100,  0, N, 32'h200, 1, 0,   N, 32'h100,  0, 1, 1, 0, 0); // collision
        add(0, I, 32'h0,    0, I, 32'h0,   1, 0,   N, 32'h200,  1, 1, 0, 0, 0);
        add(0, I, 32'h0,    0, I, 32'h0,   1, 0,   I, 32'h0,    0, 1, 1, 0, 0);
        add(0, N, 32'h10,   0, N, 32'h20,  1, 0,   N, 32'h10,   0, 1, 1, 0, 0); // streaming
        add(0, N, 32'h14,   0, N, 32'h24,  1, 0,   N, 32'h20,   1, 1, 0, 0, 0);
        add(0, N, 32'h18,   0, N, 32'h24,  1, 0,   N, 32'h14,   0, 0, 1, 0, 0);
        add(0, N, 32'h18,   0, N, 32'h28,  1, 0,   N, 32'h24,   1, 1, 0, 0, 0);
        add(0, I, 32'h0,    0, N, 32'h28,  1, 0,   N, 32'h18,   0, 0, 1, 0, 0);
        add(0, I, 32'h0,    0, I, 32'h0,   1, 0,   N, 32'h28,   1, 1, 0, 0, 0);
        add(0, I, 32'h0,    0, I, 32'h0,   1, 0,   I, 32'h0,    0, 1, 1, 0, 0);
        add(0, N, 32'h0,    3, I, 32'h0,   1, 0,   N, 32'h0,    0, 1, 1, 0, 0); // INCR4
        add(0, S, 32'h4,    3, N, 32'h200, 1, 0,   S, 32'h4,    0, 1, 1, 0, 0);
        add(0, S, 32'h8,    3, I, 32'h0,   1, 0,   S, 32'h8,    0, 1, 0, 0, 0);
        add(0, S, 32'hC,    3, I, 32'h0,   1, 0,   S, 32'hC,    0, 1, 0, 0, 0);
        add(0, I, 32'h0,    0, I, 32'h0,   1, 0,   N, 32'h200,  1, 1, 0, 0, 0);
        add(0, I, 32'h0,    0, I, 32'h0,   1, 0,   I, 32'h0,    0, 1, 1, 0, 0);
        add(0, I, 32'h0,    0, N, 32'h300, 1, 0,   N, 32'h300,  1, 1, 1, 0, 0); // wait + error
        add(0, N, 32'h400,  0, I, 32'h0,   0, 0,   I, 32'h0,    0, 1, 0, 0, 0);
        add(0, I, 32'h0,    0, I, 32'h0,   0, 0,   N, 32'h400,  0, 0, 0, 0, 0);
        add(0, I, 32'h0,    0, I, 32'h0,   0, 1,   N, 32'h400,  0, 0, 0, 0, 1);
        add(0, I, 32'h0,    0, I, 32'h0,   1, 1,   N, 32'h400,  0, 0, 1, 0, 1);
        add(0, I, 32'h0,    0, I, 32'h0,   1, 0,   I, 32'h0,    0, 1, 1, 0, 0);
        add(0, I, 32'h0,    0, N, 32'h500, 1, 0,   N, 32'h500,  1, 1, 1, 0, 0); // freeze vs new hold
        add(0, N, 32'h600,  0, N, 32'h504, 0, 0,   N, 32'h504,  1, 1, 0, 0, 0);
        add(0, I, 32'h0,    0, N, 32'h504, 0, 0,   N, 32'h504,  1, 0, 0, 0, 0);
        add(0, I, 32'h0,    0, N, 32'h504, 1, 0,   N, 32'h504,  1, 0, 1, 0, 0);
        add(0, I, 32'h0,    0, I, 32'h0,   1, 0,   N, 32'h600,  0, 0, 1, 0, 0);
        add(0, I, 32'h0,    0, I, 32'h0,   1, 0,   I, 32'h0,    0, 1, 1, 0, 0);
        add(0, N, 32'h700,  0, N, 32'h800, 1, 0,   N, 32'h700,  0, 1, 1, 0, 0); // reset with hold
        add(1, I, 32'h0,    0, I, 32'h0,   1, 0,   N, 32'h800,  1, 1, 0, 0, 0);
        add(0, I, 32'h0,    0, I, 32'h0,   1, 0,   I, 32'h0,    0, 1, 1, 0, 0);
        add(0, I, 32'h0,    0, I, 32'h0,   1, 0,   I, 32'h0,    0, 1, 1, 0, 0);

        repeat (2) @(posedge clk);
        foreach (vq[i]) begin
            @(negedge clk);
            rst = vq[i].rst;
            s0_htrans = vq[i].t0; s0_haddr = vq[i].a0; s0_hburst = vq[i].b0;
            s1_htrans = vq[i].t1; s1_haddr = vq[i].a1; s1_hburst = 3'd0;
            m_hready = vq[i].mr; m_hresp = vq[i].me;
            #2;
            chk($sformatf("v%0d m_htrans", i),  32'(o_htrans[0]),     32'(vq[i].et));
            chk($sformatf("v%0d m_haddr", i),   o_haddr[0],           vq[i].ea);
            chk($sformatf("v%0d m_hmaster", i), 32'(o_hmaster[0]),    32'(vq[i].em));
            chk($sformatf("v%0d s0_hready", i), 32'(o_s0_hready[0]),  32'(vq[i].r0));
            chk($sformatf("v%0d s1_hready", i), 32'(o_s1_hready[0]),  32'(vq[i].r1));
            chk($sformatf("v%0d s0_hresp", i),  32'(o_s0_hresp[0]),   32'(vq[i].e0));
            chk($sformatf("v%0d s1_hresp", i),  32'(o_s1_hresp[0]),   32'(vq[i].e1));
        end

        // Round-robin instance against fixed-priority, plus data-phase routing
        drv(1, I, 32'h0, I, 32'h0);
        drv(0, N, 32'h10, N, 32'h20);
        chk("rr0 tie after reset fp", 32'(o_hmaster[0]), 32'd0);
        chk("rr0 tie after reset rr", 32'(o_hmaster[1]), 32'd0);
        chk("rr0 addr rr", o_haddr[1], 32'h10);
        drv(0, I, 32'h0, I, 32'h0);
        chk("h2 held s1 rr", 32'(o_hmaster[1]), 32'd1);
        chk("h2 hwdata fp", o_hwdata[0], WD0);
        chk("h2 hwdata rr", o_hwdata[1], WD0);
        chk("h2 s0_hrdata", o_s0_hrdata[0], RD);
        chk("h2 s1_hrdata", o_s1_hrdata[1], RD);
        drv(0, N, 32'h30, I, 32'h0);
        chk("h3 hwdata s1 owner", o_hwdata[0], WD1);
        chk("h3 hmaster rr", 32'(o_hmaster[1]), 32'd0);
        drv(0, N, 32'h34, N, 32'h40);
        chk("h4 tie fp master", 32'(o_hmaster[0]), 32'd0);
        chk("h4 tie fp addr", o_haddr[0], 32'h34);
        chk("h4 tie rr master", 32'(o_hmaster[1]), 32'd1);
        chk("h4 tie rr addr", o_haddr[1], 32'h40);
        drv(0, I, 32'h0, I, 32'h0);
        drv(0, I, 32'h0, I, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
